// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg: shared APB requester types and constants.   Rev 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Bit positions inside PPROT
  localparam int PROT_PRIV   = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR  = 2;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_wait_timer: ACCESS wait-state counter with timeout detection.   Rev 1.0
// ----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pready,
  output logic timeout_hit
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // Saturating count keeps a disabled timer from wrapping on endless waits
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != C_CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      assign timeout_hit = (count_q == C_CNT_LAST) && !pready;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_initiator: valid/ready command stream to APB4 SETUP/ACCESS.  Rev 1.0
// ----------------------------------------------------------------------------
module apb_master_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  output logic [2:0]          PPROT,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;

  apb_state_e          state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic timeout_hit;
  logic xfer_done;
  logic cmd_accept;
  logic timer_clr;
  logic timer_en;

  // PREADY reaches cmd_ready directly so a new command can chain into SETUP
  always_comb begin
    xfer_done  = (state_q == ACCESS) && (PREADY || timeout_hit);
    cmd_ready  = (state_q == IDLE) || xfer_done;
    cmd_accept = cmd_valid && cmd_ready;
    timer_clr  = (state_q == SETUP);
    timer_en   = (state_q == ACCESS) && !PREADY;
  end

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk         (PCLK),
    .rst         (PRESET),
    .clr         (timer_clr),
    .en          (timer_en),
    .pready      (PREADY),
    .timeout_hit (timeout_hit)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (xfer_done) begin
          // A ready slave wins over a timeout landing in the same cycle
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !PREADY;
          rsp_err_d     = PREADY ? PSLVERR : 1'b1;
          rsp_rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (cmd_accept) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = cmd_write;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pstrb_d   = cmd_write ? cmd_strb : '0;
      pprot_d   = cmd_prot;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire
